// File: rtl/peridot_swi_flashrd_if.sv
// Avalon-MM slave bus of the SWI boot-flash read sequencer.
// The CPU side (master) drives the address, strobes and write data.
// The sequencer (slave) returns read data with zero wait states and zero read latency.
interface peridot_swi_flashrd_if;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_write;
   logic [31:0] avs_writedata;

   modport master (
      output avs_address,
      output avs_read,
      output avs_write,
      output avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address,
      input  avs_read,
      input  avs_write,
      input  avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/peridot_swi_flashrd.sv
// peridot_swi_flashrd: autonomous EPCS/SPI-flash read sequencer.
// Software programs a 24-bit address and a byte count, then sets start.
// The block issues the read command and shifts out the address.
// Data bytes are then streamed into a small FIFO that the CPU drains over Avalon-MM.
// SPI mode 0, MSB first. Each SCLK phase lasts CLKDIV+1 clocks.
// Optional build macro PERIDOT_FLASHRD_FASTREAD_EN selects FAST_READ (0x0B).
// That build also inserts 8 dummy SCLK cycles between the address and the data.
// Without the macro the block issues plain READ (0x03) and has no dummy phase.
module peridot_swi_flashrd #(
   parameter int CLKDIV          = 0,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                        csi_clk,
   input  logic                        rsi_reset,
   peridot_swi_flashrd_if.slave        avs,
   output logic                        ins_irq,
   output logic                        coe_cso_n,
   output logic                        coe_dclk,
   output logic                        coe_asdo,
   input  logic                        coe_data0
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
   localparam int DIV_W = (CLKDIV > 0) ? $clog2(CLKDIV + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV);

`ifdef PERIDOT_FLASHRD_FASTREAD_EN
   localparam logic [7:0] READ_CMD = 8'h0B;
`else
   localparam logic [7:0] READ_CMD = 8'h03;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
`ifdef PERIDOT_FLASHRD_FASTREAD_EN
      ST_DUMMY,
`endif
      ST_DATA,
      ST_FINISH
   } state_t;

   // ---------------- software-visible registers ----------------
   logic [23:0] addr_reg;
   logic [7:0]  len_reg;
   logic        irqena_reg;
   logic        done_reg;

   // ---------------- sequencer state ----------------
   state_t            state_reg;
   logic              cso_n_reg;
   logic              dclk_reg;
   logic              asdo_reg;
   logic [DIV_W-1:0]  div_cnt_reg;
   logic [4:0]        bit_cnt_reg;
   logic [31:0]       tx_sr_reg;
   logic [7:0]        rx_sr_reg;
   logic [7:0]        bytes_left_reg;
   logic              push_req_reg;
   logic [7:0]        push_data_reg;

   // ---------------- data FIFO ----------------
   logic [7:0]                 fifo_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [CNT_W-1:0]           fifo_cnt_reg;

   // ---------------- decoded bus events ----------------
   logic       wr_reg1;
   logic       busy;
   logic       shifting;
   logic       start_fire;
   logic       abort_fire;
   logic       done_clr;
   logic       fifo_valid;
   logic       pop;
   logic [CNT_W:0] fifo_level_eff;
   logic       fifo_full_eff;
   logic       stall;
   logic [4:0] unit_last;
   logic       unused_wdata;

   assign wr_reg1    = avs.avs_write && (avs.avs_address == 2'd1);
   assign busy       = (state_reg != ST_IDLE);
   assign shifting   = busy && (state_reg != ST_FINISH);
   assign start_fire = wr_reg1 && avs.avs_writedata[0] && (state_reg == ST_IDLE);
   assign abort_fire = wr_reg1 && avs.avs_writedata[2] && shifting;
   assign done_clr   = wr_reg1 && avs.avs_writedata[3];

   assign fifo_valid = (fifo_cnt_reg != '0);
   assign pop        = avs.avs_read && (avs.avs_address == 2'd2) && fifo_valid;

   // A byte that is registered but not yet written still occupies a slot.
   // Count it here, so the next byte never starts into a FIFO that will be full.
   assign fifo_level_eff = {1'b0, fifo_cnt_reg} + {{CNT_W{1'b0}}, push_req_reg};
   assign fifo_full_eff  = (fifo_level_eff >= (CNT_W+1)'(DEPTH));

   // Hold the clock low at a byte boundary while the FIFO has no room.
   assign stall = (state_reg == ST_DATA) && !dclk_reg && (bit_cnt_reg == 5'd0) && fifo_full_eff;

   assign ins_irq   = done_reg & irqena_reg;
   assign coe_cso_n = cso_n_reg;
   assign coe_dclk  = dclk_reg;
   assign coe_asdo  = asdo_reg;

   assign unused_wdata = &{1'b0, avs.avs_writedata[31:24]};

   // Index of the last bit in the current shift unit (address is 24 bits, the rest 8).
   always_comb begin
      unit_last = 5'd7;
      if (state_reg == ST_ADDR) begin
         unit_last = 5'd23;
      end
   end

   // Register file writes. Length and irq enable update even while a transfer runs.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         addr_reg   <= '0;
         len_reg    <= '0;
         irqena_reg <= 1'b0;
      end else begin
         if (avs.avs_write && (avs.avs_address == 2'd0)) begin
            addr_reg <= avs.avs_writedata[23:0];
         end
         if (wr_reg1) begin
            len_reg    <= avs.avs_writedata[15:8];
            irqena_reg <= avs.avs_writedata[1];
         end
      end
   end

   // Transfer sequencer: SPI framing, bit shifting, byte counting, abort and done.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         state_reg      <= ST_IDLE;
         cso_n_reg      <= 1'b1;
         dclk_reg       <= 1'b0;
         asdo_reg       <= 1'b0;
         div_cnt_reg    <= '0;
         bit_cnt_reg    <= '0;
         tx_sr_reg      <= '0;
         rx_sr_reg      <= '0;
         bytes_left_reg <= '0;
         push_req_reg   <= 1'b0;
         push_data_reg  <= '0;
         done_reg       <= 1'b0;
      end else begin
         push_req_reg <= 1'b0;
         if (done_clr) begin
            done_reg <= 1'b0;
         end

         case (state_reg)
            ST_IDLE: begin
               dclk_reg <= 1'b0;
               asdo_reg <= 1'b0;
               if (start_fire) begin
                  // Command and address go out as one continuous 32-bit word.
                  state_reg      <= ST_CMD;
                  cso_n_reg      <= 1'b0;
                  div_cnt_reg    <= '0;
                  bit_cnt_reg    <= '0;
                  tx_sr_reg      <= {READ_CMD, addr_reg};
                  asdo_reg       <= READ_CMD[7];
                  bytes_left_reg <= avs.avs_writedata[15:8];
                  done_reg       <= 1'b0;
               end
            end

            ST_FINISH: begin
               // Chip select stays high for CLKDIV+1 clocks before the block is idle again.
               if (div_cnt_reg == DIV_LAST) begin
                  state_reg   <= ST_IDLE;
                  done_reg    <= 1'b1;
                  div_cnt_reg <= '0;
               end else begin
                  div_cnt_reg <= div_cnt_reg + 1'b1;
               end
            end

            default: begin
               if (abort_fire) begin
                  state_reg   <= ST_FINISH;
                  cso_n_reg   <= 1'b1;
                  dclk_reg    <= 1'b0;
                  asdo_reg    <= 1'b0;
                  div_cnt_reg <= '0;
               end else if (stall) begin
                  div_cnt_reg <= '0;
               end else if (div_cnt_reg != DIV_LAST) begin
                  div_cnt_reg <= div_cnt_reg + 1'b1;
               end else begin
                  div_cnt_reg <= '0;
                  if (!dclk_reg) begin
                     // Rising edge: sample MISO. The 8th data bit completes a byte.
                     dclk_reg  <= 1'b1;
                     rx_sr_reg <= {rx_sr_reg[6:0], coe_data0};
                     if ((state_reg == ST_DATA) && (bit_cnt_reg == 5'd7)) begin
                        push_req_reg  <= 1'b1;
                        push_data_reg <= {rx_sr_reg[6:0], coe_data0};
                     end
                  end else begin
                     // Falling edge: present the next MOSI bit. Zeros follow the address.
                     dclk_reg  <= 1'b0;
                     tx_sr_reg <= {tx_sr_reg[30:0], 1'b0};
                     asdo_reg  <= tx_sr_reg[30];
                     if (bit_cnt_reg == unit_last) begin
                        bit_cnt_reg <= '0;
                        case (state_reg)
                           ST_CMD:  state_reg <= ST_ADDR;
`ifdef PERIDOT_FLASHRD_FASTREAD_EN
                           ST_ADDR:  state_reg <= ST_DUMMY;
                           ST_DUMMY: state_reg <= ST_DATA;
`else
                           ST_ADDR: state_reg <= ST_DATA;
`endif
                           default: begin
                              if (bytes_left_reg == 8'd0) begin
                                 state_reg <= ST_FINISH;
                                 cso_n_reg <= 1'b1;
                                 asdo_reg  <= 1'b0;
                              end else begin
                                 bytes_left_reg <= bytes_left_reg - 1'b1;
                              end
                           end
                        endcase
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

   // FIFO storage: write port only. The array is read combinationally for zero-latency reads.
   always_ff @(posedge csi_clk) begin
      if (push_req_reg) begin
         fifo_mem[wr_ptr_reg] <= push_data_reg;
      end
   end

   // FIFO pointers and occupancy. A start flushes the FIFO. Push and pop in one cycle cancel.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else if (start_fire) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else begin
         if (push_req_reg) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(push_req_reg) - CNT_W'(pop);
      end
   end

   // Register read mux: combinational, zero wait states.
   always_comb begin
      avs.avs_readdata = '0;
      case (avs.avs_address)
         2'd0: avs.avs_readdata = {8'h00, addr_reg};
         2'd1: avs.avs_readdata = {16'h0000, len_reg, 4'b0000, done_reg, 1'b0, irqena_reg, busy};
         2'd2: avs.avs_readdata = {23'd0, fifo_valid, fifo_valid ? fifo_mem[rd_ptr_reg] : 8'h00};
         default: avs.avs_readdata = 32'(fifo_cnt_reg);
      endcase
   end

endmodule

// File: tb/tb_peridot_swi_flashrd.sv
// Self-checking bench for peridot_swi_flashrd. It contains a behavioural SPI flash.
// The flash captures the header and returns bytes from flash_byte().
// Register vectors are applied from a table, followed by hand-written corner sequences.
// A randomized run then checks transfers against a queue-based expectation.
module tb_peridot_swi_flashrd;
   localparam int CLKDIV = 0;
`ifdef PERIDOT_FLASHRD_FASTREAD_EN
   localparam int         HDR_BITS = 40;
   localparam logic [7:0] EXP_CMD  = 8'h0B;
`else
   localparam int         HDR_BITS = 32;
   localparam logic [7:0] EXP_CMD  = 8'h03;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ins_irq, cso_n, dclk, asdo;
   logic data0 = 1'b0;

   peridot_swi_flashrd_if bus();

   peridot_swi_flashrd #(.CLKDIV(CLKDIV), .FIFO_DEPTH_LOG2(4)) dut (
      .csi_clk   (clk),
      .rsi_reset (rst),
      .avs       (bus),
      .ins_irq   (ins_irq),
      .coe_cso_n (cso_n),
      .coe_dclk  (dclk),
      .coe_asdo  (asdo),
      .coe_data0 (data0)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Flash content: a few fixed bytes, otherwise a simple address hash.
   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      logic [7:0] r;
      case (a)
         24'h123456: r = 8'hA5;
         24'h123457: r = 8'h5A;
         24'h123458: r = 8'h00;
         24'h123459: r = 8'hFF;
         default:    r = (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
      endcase
      return r;
   endfunction

   // ---------------- behavioural SPI flash (mode 0) ----------------
   int          fl_bits = 0;
   logic [31:0] fl_hdr = '0;
   logic [31:0] last_hdr = '0;
   int          last_rises = 0;
   int          last_low_clks = 0;
   time         cso_fall_t = 0;

   always @(negedge cso_n) begin
      fl_bits    = 0;
      fl_hdr     = '0;
      cso_fall_t = $time;
   end

   always @(posedge cso_n) begin
      last_rises    = fl_bits;
      last_low_clks = int'(($time - cso_fall_t) / 10);
      last_hdr      = fl_hdr;
   end

   always @(posedge dclk) begin
      if (!cso_n) begin
         if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], asdo};
         fl_bits++;
      end
   end

   always @(negedge dclk) begin
      if (!cso_n && fl_bits >= HDR_BITS) begin
         int idx;
         logic [7:0] b;
         idx   = fl_bits - HDR_BITS;
         b     = flash_byte(fl_hdr[23:0] + 24'(idx / 8));
         data0 = b[7 - (idx % 8)];
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.avs_address   = a;
      bus.avs_writedata = d;
      bus.avs_write     = 1'b1;
      @(negedge clk);
      bus.avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.avs_address = a;
      bus.avs_read    = 1'b1;
      #1 d = bus.avs_readdata;
      @(negedge clk);
      bus.avs_read    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      logic [31:0] d;
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         rd(2'd1, d);
         if (d[3]) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd1);
   endtask

   task automatic wait_bits(input string name, input int n, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (fl_bits >= n && !cso_n) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd1);
   endtask

   typedef struct {
      logic        is_wr;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [23:0] a;
      logic [7:0]  exp_q[$];

      bus.avs_address   = '0;
      bus.avs_read      = 1'b0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = '0;

      vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
      vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
      vecs[4]  = '{1'b1, 2'd0, 32'hFFABCDEF, 32'h0};
      vecs[5]  = '{1'b0, 2'd0, 32'h0,        32'h00ABCDEF};
      vecs[6]  = '{1'b1, 2'd1, 32'h0000AB02, 32'h0};
      vecs[7]  = '{1'b0, 2'd1, 32'h0,        32'h0000AB02};
      vecs[8]  = '{1'b1, 2'd1, 32'h12345AF0, 32'h0};
      vecs[9]  = '{1'b0, 2'd1, 32'h0,        32'h00005A00};
      vecs[10] = '{1'b1, 2'd0, 32'h00000000, 32'h0};
      vecs[11] = '{1'b0, 2'd0, 32'h0,        32'h0};

      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("reset cso_n", {31'd0, cso_n}, 32'd1);
      check("reset dclk",  {31'd0, dclk},  32'd0);
      check("reset asdo",  {31'd0, asdo},  32'd0);
      check("reset irq",   {31'd0, ins_irq}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d);
         else begin
            rd(vecs[i].a, d);
            check($sformatf("vec%0d reg%0d", i, vecs[i].a), d, vecs[i].exp);
         end
      end

      // ---- basic read of 4 bytes ----
      wr(2'd0, 32'h00123456);
      wr(2'd1, 32'h00000301);
      check("t1 cso_n low after start", {31'd0, cso_n}, 32'd0);
      rd(2'd1, d);
      check("t1 busy", {31'd0, d[0]}, 32'd1);
      wait_done("t1 done wait", 2000);
      check("t1 header", last_hdr, {EXP_CMD, 24'h123456});
      check("t1 dclk periods", 32'(last_rises), 32'(HDR_BITS + 32));
      check("t1 cso low clocks", 32'(last_low_clks), 32'(2 * (HDR_BITS + 32) * (CLKDIV + 1)));
      rd(2'd3, d);  check("t1 count", d, 32'd4);
      rd(2'd2, d);  check("t1 pop0", d, 32'h1A5);
      rd(2'd2, d);  check("t1 pop1", d, 32'h15A);
      rd(2'd2, d);  check("t1 pop2", d, 32'h100);
      rd(2'd2, d);  check("t1 pop3", d, 32'h1FF);
      rd(2'd2, d);  check("t1 empty", d, 32'h000);
      rd(2'd3, d);  check("t1 count after empty read", d, 32'd0);
      rd(2'd1, d);  check("t1 reg1", d, 32'h00000308);

      // ---- interrupt ----
      wr(2'd1, 32'h00000003);
      check("t2 irq low after start", {31'd0, ins_irq}, 32'd0);
      wait_done("t2 done wait", 2000);
      check("t2 irq high", {31'd0, ins_irq}, 32'd1);
      wr(2'd1, 32'h00000008);
      check("t2 irq cleared", {31'd0, ins_irq}, 32'd0);

      // ---- FIFO full stall, crossing the top of the address space ----
      wr(2'd0, 32'h00FFFFF8);
      wr(2'd1, 32'h00001F01);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 2000 && !seen; i++) begin
            rd(2'd3, d);
            if (d == 32'd16) seen = 1'b1;
         end
         check("t3 reach full", {31'd0, seen}, 32'd1);
      end
      repeat (40) @(negedge clk);
      rd(2'd3, d);  check("t3 count held", d, 32'd16);
      check("t3 dclk held low", {31'd0, dclk}, 32'd0);
      check("t3 cso held low", {31'd0, cso_n}, 32'd0);
      rd(2'd1, d);  check("t3 busy", {31'd0, d[0]}, 32'd1);
      for (int i = 0; i < 32; i++) begin
         logic got;
         got = 1'b0;
         for (int k = 0; k < 200 && !got; k++) begin
            rd(2'd2, d);
            if (d[8]) got = 1'b1;
         end
         check($sformatf("t3 byte%0d", i), d, {23'd0, 1'b1, flash_byte(24'hFFFFF8 + 24'(i))});
      end
      wait_done("t3 done wait", 2000);
      rd(2'd3, d);  check("t3 drained", d, 32'd0);

      // ---- abort during address phase ----
      wr(2'd0, 32'h00654321);
      wr(2'd1, 32'h00000F01);
      wait_bits("t4 reach addr bit 12", 20, 2000);
      wr(2'd1, 32'h00000004);
      check("t4 cso high after abort", {31'd0, cso_n}, 32'd1);
      check("t4 dclk low after abort", {31'd0, dclk}, 32'd0);
      repeat (3) @(negedge clk);
      rd(2'd1, d);  check("t4 reg1", d, 32'h00000008);
      rd(2'd3, d);  check("t4 count", d, 32'd0);

      // ---- start re-written while busy ----
      wr(2'd0, 32'h0000ABC0);
      wr(2'd1, 32'h00000201);
      wr(2'd0, 32'h00777777);
      wr(2'd1, 32'h00000701);
      wait_done("t5 done wait", 2000);
      check("t5 header", last_hdr, {EXP_CMD, 24'h00ABC0});
      rd(2'd3, d);  check("t5 count", d, 32'd3);
      for (int i = 0; i < 3; i++) begin
         rd(2'd2, d);
         check($sformatf("t5 byte%0d", i), d, {23'd0, 1'b1, flash_byte(24'h00ABC0 + 24'(i))});
      end
      rd(2'd0, d);  check("t5 addr reg", d, 32'h00777777);
      rd(2'd1, d);  check("t5 reg1", d, 32'h00000708);

      // ---- reset mid-DATA ----
      wr(2'd0, 32'h00001000);
      wr(2'd1, 32'h00002001);
      wait_bits("t6 reach data", HDR_BITS + 9, 2000);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6 cso async", {31'd0, cso_n}, 32'd1);
      check("t6 dclk async", {31'd0, dclk}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd(2'd3, d);  check("t6 count", d, 32'd0);
      rd(2'd1, d);  check("t6 reg1", d, 32'd0);

      // ---- randomized transfers with random pop timing ----
      for (int t = 0; t < 6; t++) begin
         int  len, got_n, guard;
         logic irq, done_seen, finished;
         a   = 24'($urandom);
         len = int'($urandom_range(0, 40));
         irq = 1'($urandom_range(0, 1));
         exp_q.delete();
         for (int i = 0; i <= len; i++) exp_q.push_back(flash_byte(a + 24'(i)));
         wr(2'd0, {8'd0, a});
         wr(2'd1, {16'd0, 8'(len), 6'd0, irq, 1'b1});
         got_n = 0; done_seen = 1'b0; finished = 1'b0; guard = 0;
         while (!finished && guard < 8000) begin
            guard++;
            if ($urandom_range(0, 2) != 0) begin
               rd(2'd2, d);
               if (d[8]) begin
                  logic [31:0] e;
                  e = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q[0]} : 32'hBAD;
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  check($sformatf("rnd%0d byte%0d", t, got_n), d, e);
                  got_n++;
               end else if (done_seen) begin
                  finished = 1'b1;
               end
            end else begin
               rd(2'd1, d);
               if (d[3]) done_seen = 1'b1;
            end
         end
         check($sformatf("rnd%0d finished", t), {31'd0, finished}, 32'd1);
         check($sformatf("rnd%0d byte count", t), 32'(got_n), 32'(len + 1));
         check($sformatf("rnd%0d header", t), last_hdr, {EXP_CMD, a});
         check($sformatf("rnd%0d irq", t), {31'd0, ins_irq}, {31'd0, irq});
         wr(2'd1, 32'h00000008);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
